// File: rtl/arashi_mt_queue_pkg.sv
// rtl/arashi_mt_queue_pkg.sv - shared parameters and slice helpers for the multi-thread queue
package arashi_pkg;

  localparam int THREAD_NUM_WIDTH_MIN = 1;
  localparam int THREAD_NUM_WIDTH_MAX = 4;

  // Bits needed to index n threads; never below 1 so single-bit indices stay legal.
  function automatic int thread_idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int data_lo(input int thread, input int data_width);
    return thread * data_width;
  endfunction

  function automatic int level_lo(input int thread, input int region_width);
    return thread * (region_width + 1);
  endfunction

endpackage

// File: rtl/arashi_mt_queue_if.sv
// rtl/arashi_mt_queue_if.sv - thread-side write/read/status bundle of the multi-thread queue
interface arashi_mt_queue_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_WIDTH        = 10,
  parameter int THREAD_NUM_WIDTH = 2
);
  localparam int T  = 1 << THREAD_NUM_WIDTH;
  localparam int RW = MEM_WIDTH - THREAD_NUM_WIDTH;

  logic [T-1:0]            w_ena;
  logic [DATA_WIDTH*T-1:0] data_in;
  logic [T-1:0]            w_ready;
  logic [T-1:0]            r_ena;
  logic [T-1:0]            r_ready;
  logic [DATA_WIDTH*T-1:0] data_out;
  logic [T-1:0]            full;
  logic [T-1:0]            empty;
  logic [(RW+1)*T-1:0]     level;

  modport master (
    output w_ena, data_in, r_ena,
    input  w_ready, r_ready, data_out, full, empty, level
  );

  modport slave (
    input  w_ena, data_in, r_ena,
    output w_ready, r_ready, data_out, full, empty, level
  );

endinterface

// File: rtl/arashi_rr_arbiter.sv
// rtl/arashi_rr_arbiter.sv - round-robin one-hot arbiter; search starts one past the last grant
module arashi_rr_arbiter
  import arashi_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = thread_idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] ptr
);

  logic          found;
  logic [IW-1:0] gidx;

  // N is a power of two, so the IW-bit sum wraps the search modulo N for free.
  always_comb begin
    logic [IW-1:0] idx;
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      idx = ptr + IW'(off);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gidx        = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= gidx + IW'(1);
    end
  end

endmodule

// File: rtl/arashi_mt_queue.sv
// rtl/arashi_mt_queue.sv - per-thread circular FIFOs carved from one 1W/1R memory
module arashi_mt_queue
  import arashi_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_WIDTH        = 10,
  parameter int THREAD_NUM_WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  arashi_mt_queue_if.slave  q
);

  localparam int T  = 1 << THREAD_NUM_WIDTH;
  localparam int TW = THREAD_NUM_WIDTH;
  localparam int RW = MEM_WIDTH - THREAD_NUM_WIDTH;
  localparam int D  = 1 << RW;

  if (THREAD_NUM_WIDTH < THREAD_NUM_WIDTH_MIN || THREAD_NUM_WIDTH > THREAD_NUM_WIDTH_MAX) begin : g_bad_tnw
    $error("arashi_mt_queue: THREAD_NUM_WIDTH out of range 1..4");
  end
  if (MEM_WIDTH <= THREAD_NUM_WIDTH) begin : g_bad_mw
    $error("arashi_mt_queue: MEM_WIDTH must exceed THREAD_NUM_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_WIDTH)-1];

  logic [DATA_WIDTH-1:0] din    [T];
  logic [DATA_WIDTH-1:0] dout_q [T];
  logic [RW-1:0]         wr_ptr [T];
  logic [RW-1:0]         rd_ptr [T];
  logic [RW:0]           count  [T];
  logic [RW:0]           cnt_next [T];

  logic [T-1:0]  full_q, empty_q, r_ready_q;
  logic [T-1:0]  w_elig, r_elig, w_grant, r_grant, w_fire, r_fire;
  logic [TW-1:0] w_idx, r_idx;
  logic [TW-1:0] w_rr_ptr_unused, r_rr_ptr_unused;

  // Eligibility looks only at registered status, never at this cycle's other port.
  assign w_elig = q.w_ena & ~full_q;
  assign r_elig = q.r_ena & ~empty_q;

  arashi_rr_arbiter #(.N(T)) u_w_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (w_elig),
    .adv   (~rst),
    .grant (w_grant),
    .ptr   (w_rr_ptr_unused)
  );

  arashi_rr_arbiter #(.N(T)) u_r_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (r_elig),
    .adv   (~rst),
    .grant (r_grant),
    .ptr   (r_rr_ptr_unused)
  );

  assign w_fire = rst ? '0 : w_grant;
  assign r_fire = rst ? '0 : r_grant;

  always_comb begin
    w_idx = '0;
    r_idx = '0;
    for (int i = 0; i < T; i++) begin
      if (w_grant[i]) w_idx = TW'(i);
      if (r_grant[i]) r_idx = TW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < T; i++) begin
      cnt_next[i] = count[i] + (RW+1)'(w_fire[i]) - (RW+1)'(r_fire[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (|w_fire) begin
      mem[{w_idx, wr_ptr[w_idx]}] <= din[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready_q <= '0;
      full_q    <= '0;
      empty_q   <= '1;
      for (int i = 0; i < T; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      r_ready_q <= r_fire;
      if (|r_fire) begin
        dout_q[r_idx] <= mem[{r_idx, rd_ptr[r_idx]}];
      end
      for (int i = 0; i < T; i++) begin
        if (w_fire[i]) wr_ptr[i] <= wr_ptr[i] + RW'(1);
        if (r_fire[i]) rd_ptr[i] <= rd_ptr[i] + RW'(1);
        count[i]   <= cnt_next[i];
        full_q[i]  <= (cnt_next[i] == (RW+1)'(D));
        empty_q[i] <= (cnt_next[i] == '0);
      end
    end
  end

  for (genvar i = 0; i < T; i++) begin : g_slice
    assign din[i] = q.data_in[data_lo(i, DATA_WIDTH) +: DATA_WIDTH];
    assign q.data_out[data_lo(i, DATA_WIDTH) +: DATA_WIDTH] = dout_q[i];
    assign q.level[level_lo(i, RW) +: RW+1] = count[i];
  end

  assign q.w_ready = w_fire;
  assign q.r_ready = r_ready_q;
  assign q.full    = full_q;
  assign q.empty   = empty_q;

endmodule

// File: tb/tb_arashi_mt_queue.sv
// tb/tb_arashi_mt_queue.sv - directed self-checking bench for arashi_mt_queue (D=4, 4 threads)
module tb_arashi_mt_queue;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  arashi_mt_queue_if #(.DATA_WIDTH(32), .MEM_WIDTH(4), .THREAD_NUM_WIDTH(2)) bus ();

  arashi_mt_queue #(.DATA_WIDTH(32), .MEM_WIDTH(4), .THREAD_NUM_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.w_ena   = '0;
    bus.r_ena   = '0;
    bus.data_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] dout(input int t);
    return bus.data_out[t*32 +: 32];
  endfunction

  function automatic logic [31:0] lvl(input int t);
    return 32'(bus.level[t*3 +: 3]);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    cyc();
    bus.w_ena = 4'hF;
    #1;
    check("w_ready_in_reset", 32'(bus.w_ready), 32'h0);
    cyc();
    bus.w_ena = '0;
    rst = 1'b0;
    #1;
    check("reset_empty", 32'(bus.empty), 32'hF);
    check("reset_full", 32'(bus.full), 32'h0);
    check("reset_level", 32'(bus.level), 32'h0);
    check("reset_w_ready", 32'(bus.w_ready), 32'h0);
    check("reset_r_ready", 32'(bus.r_ready), 32'h0);

    // Fill and drain thread 0
    for (int k = 0; k < 4; k++) begin
      bus.w_ena[0] = 1'b1;
      bus.data_in[31:0] = 32'hA0 + 32'(k);
      #1;
      check("fill_w_ready", 32'(bus.w_ready), 32'h1);
      cyc();
      if (k == 0) begin
        check("first_write_level", lvl(0), 32'd1);
        check("first_write_empty", 32'(bus.empty[0]), 32'h0);
      end
    end
    check("fill_full", 32'(bus.full[0]), 32'h1);
    check("fill_level", lvl(0), 32'd4);
    bus.data_in[31:0] = 32'hA4;
    #1;
    check("fifth_write_refused", 32'(bus.w_ready), 32'h0);
    cyc();
    bus.w_ena = '0;
    check("level_after_refused", lvl(0), 32'd4);
    bus.r_ena[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("drain_r_ready", 32'(bus.r_ready), 32'h1);
      check("drain_data", dout(0), 32'hA0 + 32'(k));
    end
    bus.r_ena = '0;
    check("drain_empty", 32'(bus.empty), 32'hF);
    cyc();
    check("drain_no_pulse", 32'(bus.r_ready), 32'h0);
    check("drain_data_hold", dout(0), 32'hA3);

    // Fairness
    do_reset();
    bus.w_ena = 4'hF;
    for (int k = 0; k < 8; k++) begin
      for (int t = 0; t < 4; t++) bus.data_in[t*32 +: 32] = 32'(t * 16 + k);
      #1;
      check("rr_grant", 32'(bus.w_ready), 32'(1 << (k % 4)));
      cyc();
    end
    bus.w_ena = '0;
    check("rr_levels", 32'(bus.level), 32'h492);

    // Wrap-around on thread 2
    do_reset();
    for (int k = 0; k < 7; k++) begin
      bus.w_ena[2] = (k < 6);
      bus.data_in[64 +: 32] = 32'h10 + 32'(k);
      bus.r_ena[2] = (k >= 1);
      #1;
      if (k < 6) check("wrap_w_ready", 32'(bus.w_ready), 32'h4);
      cyc();
      if (k >= 1) begin
        check("wrap_r_ready", 32'(bus.r_ready), 32'h4);
        check("wrap_data", dout(2), 32'h10 + 32'(k - 1));
      end
    end
    idle_inputs();
    check("wrap_empty", 32'(bus.empty[2]), 32'h1);
    check("wrap_level", lvl(2), 32'd0);

    // Concurrent read and write on a full region
    do_reset();
    bus.w_ena[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.data_in[32 +: 32] = 32'h20 + 32'(k);
      cyc();
    end
    check("conc_full", 32'(bus.full[1]), 32'h1);
    bus.data_in[32 +: 32] = 32'h24;
    bus.r_ena[1] = 1'b1;
    #1;
    check("conc_write_refused", 32'(bus.w_ready), 32'h0);
    cyc();
    idle_inputs();
    check("conc_r_ready", 32'(bus.r_ready), 32'h2);
    check("conc_data", dout(1), 32'h20);
    check("conc_level", lvl(1), 32'd3);
    check("conc_not_full", 32'(bus.full[1]), 32'h0);

    // Reset mid-stream on thread 3
    do_reset();
    bus.w_ena[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.data_in[96 +: 32] = 32'h30 + 32'(k);
      cyc();
    end
    bus.w_ena = '0;
    check("mid_level_before", lvl(3), 32'd3);
    bus.r_ena[3] = 1'b1;
    rst = 1'b1;
    cyc();
    check("mid_no_r_ready", 32'(bus.r_ready), 32'h0);
    rst = 1'b0;
    bus.r_ena = '0;
    cyc();
    check("mid_no_r_ready_after", 32'(bus.r_ready), 32'h0);
    check("mid_empty", 32'(bus.empty[3]), 32'h1);
    check("mid_level", lvl(3), 32'd0);
    check("mid_data_cleared", dout(3), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
